// File: rtl/fft_in_buf8.sv
// rtl/fft_in_buf8.sv - ping-pong serial-to-parallel input buffer for the 8-point FFT core
module fft_in_buf8 #(
  parameter int DATA_WID = 16,
  parameter int N_PT     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  input  logic                  in_sop_i,
  input  logic [DATA_WID-1:0]   in_re_i,
  input  logic [DATA_WID-1:0]   in_im_i,
  output logic                  in_ready_o,
  output logic [8*DATA_WID-1:0] fft_data_re_o,
  output logic [8*DATA_WID-1:0] fft_data_im_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  sop_err_o
);

  localparam int CNT_W = $clog2(N_PT);

  typedef logic [DATA_WID-1:0] samp_t;

  // Two banks of lane registers; bank index is wr_bank / rd_bank.
  samp_t bank_re [2][N_PT];
  samp_t bank_im [2][N_PT];

  logic             wr_bank;
  logic             rd_bank;
  logic [CNT_W-1:0] wr_cnt;
  logic [1:0]       full;
  logic             sop_err;

  logic             accept;
  logic             early_sop;
  logic             frame_done;
  logic             consume;
  logic [CNT_W-1:0] wr_lane;
  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       full_next;

  // The FFT core expects its inputs in bit-reversed order, so sample n lands in lane bitrev(n).
  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  assign in_ready_o  = !full[wr_bank];
  assign out_valid_o = full[rd_bank];
  assign sop_err_o   = sop_err;

  // Input acceptance, early-SOP detection and write-lane selection.
  always_comb begin
    accept     = 1'b0;
    early_sop  = 1'b0;
    frame_done = 1'b0;
    wr_lane    = '0;
    cnt_next   = wr_cnt;
    accept     = in_valid_i && !full[wr_bank];
    // A sop mid-frame restarts the current bank at lane 0; the stale lanes get overwritten as it refills.
    early_sop  = accept && in_sop_i && (wr_cnt != '0);
    if (early_sop) begin
      wr_lane  = '0;
      cnt_next = CNT_W'(1);
    end else begin
      wr_lane  = bitrev3(wr_cnt);
      cnt_next = CNT_W'(wr_cnt + CNT_W'(1));
    end
    frame_done = accept && !early_sop && (wr_cnt == CNT_W'(N_PT - 1));
  end

  // Output handshake and bank occupancy update.
  always_comb begin
    consume   = 1'b0;
    full_next = full;
    consume   = full[rd_bank] && out_ready_i;
    // Completion and consumption can coincide: a bank being written is never full, so they always target different banks.
    if (consume) begin
      full_next[rd_bank] = 1'b0;
    end
    if (frame_done) begin
      full_next[wr_bank] = 1'b1;
    end
  end

  // Control state: bank pointers, write counter, occupancy flags and the sop error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      full    <= 2'b00;
      sop_err <= 1'b0;
    end else begin
      full    <= full_next;
      sop_err <= early_sop;
      if (accept) begin
        wr_cnt <= cnt_next;
      end
      if (frame_done) begin
        wr_bank <= !wr_bank;
      end
      if (consume) begin
        rd_bank <= !rd_bank;
      end
    end
  end

  // Sample storage: write the accepted sample into its bit-reversed lane of the bank being filled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int l = 0; l < N_PT; l++) begin
          bank_re[b][l] <= '0;
          bank_im[b][l] <= '0;
        end
      end
    end else if (accept) begin
      bank_re[wr_bank][wr_lane] <= in_re_i;
      bank_im[wr_bank][wr_lane] <= in_im_i;
    end
  end

  // Present the read bank as packed lane vectors; lane i occupies bits [(i+1)*DATA_WID-1 : i*DATA_WID].
  always_comb begin
    fft_data_re_o = '0;
    fft_data_im_o = '0;
    for (int i = 0; i < 8; i++) begin
      fft_data_re_o[i*DATA_WID +: DATA_WID] = bank_re[rd_bank][i];
      fft_data_im_o[i*DATA_WID +: DATA_WID] = bank_im[rd_bank][i];
    end
  end

endmodule

// File: doc/fft_in_buf8.md
Name: fft_in_buf8

Overview:
- Serial-to-parallel ping-pong input buffer directly upstream of the 8-point FFT core.
- Accepts one complex sample per handshake and places it in bit-reversed lane order.
- Presents a complete 8-lane real/imag vector to the core with a valid/ready handshake.
- Two banks allow frame n+1 to load while frame n is held for the consumer.

Parameters:
- DATA_WID, `DATA_WID from fft_defines.vh: width of one real or imaginary sample (two's complement).
- N_PT, 8: points per frame. Fixed at 8; lane index is 3-bit bit-reversal.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- in_valid_i  input  1  sample valid
- in_sop_i  input  1  marks sample 0 of a frame; qualified by in_valid_i
- in_re_i  input  DATA_WID  sample real part
- in_im_i  input  DATA_WID  sample imaginary part
- in_ready_o  output  1  buffer can accept a sample this cycle
- fft_data_re_o  output  8*DATA_WID  lane i at [(i+1)*DATA_WID-1 : i*DATA_WID]
- fft_data_im_o  output  8*DATA_WID  same packing
- out_valid_o  output  1  full frame available
- out_ready_i  input  1  consumer accepts frame
- sop_err_o  output  1  one-cycle pulse: partial frame discarded

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Storage: two banks, each 8 x (re, im) registers. State: wr_bank, rd_bank (1b each), wr_cnt (3b), full[1:0].
- Reset values:
  - wr_bank = rd_bank = 0, wr_cnt = 0, full = 00.
  - out_valid_o = 0, sop_err_o = 0, in_ready_o = 1.
  - Bank contents are cleared to 0, so fft_data_*_o = 0.
- Input handshake:
  - in_ready_o = !full[wr_bank] (combinational from registers).
  - Accept = in_valid_i && in_ready_o.
  - On accept, the sample is written to bank[wr_bank] at lane bitrev3(wr_cnt). Mapping: 0→0, 1→4, 2→2, 3→6, 4→1, 5→5, 6→3, 7→7.
  - wr_cnt then increments, wrapping 7→0.
- Frame completion:
  - Accepting with wr_cnt==7 sets full[wr_bank] and toggles wr_bank at the same edge.
- SOP handling:
  - An accept with in_sop_i=1 and wr_cnt≠0 abandons the partial frame.
  - The sample is written as lane 0 and wr_cnt becomes 1.
  - sop_err_o pulses for the next cycle.
  - Stale lanes in that bank are overwritten as the frame refills.
  - in_sop_i with wr_cnt==0 is normal. Absence of sop at wr_cnt==0 is legal (free-running framing).
- Output:
  - out_valid_o = full[rd_bank].
  - fft_data_*_o = bank[rd_bank], always driven, stable while out_valid_o=1.
  - On out_valid_o && out_ready_i: clear full[rd_bank] and toggle rd_bank.
- Latency: 8th sample accepted at edge k → out_valid_o=1 in the cycle after edge k. Output is not combinational from in_*.
- Throughput: 1 sample/cycle sustained when out_ready_i is asserted at least once per 8 cycles.
- Simultaneous events:
  - Completing a write to one bank and consuming the other bank in the same edge both take effect.
  - Since wr_bank≠rd_bank whenever both banks are active, no conflict exists.
- Full condition:
  - Both banks full → in_ready_o=0, input stalls.
  - The first out handshake frees a bank and in_ready_o rises the next cycle (no combinational ready path from out_ready_i).
- Reset mid-operation: all state returns to reset values immediately. Partial and full frames are lost, and out_valid_o drops asynchronously.
- No arithmetic, scaling or rounding. Data passes bit-exact.

Test Plan:
- Single frame: after reset, feed re=n+1, im=-(n+1) for n=0..7 back-to-back, with sop on n=0 and out_ready_i=0.
  - out_valid_o=1 one cycle after the 8th accept.
  - Lanes re[0..7] = 1,5,3,7,2,6,4,8.
- Back-pressure: hold out_ready_i=0 and stream 24 samples.
  - in_ready_o=1 for the first 16 accepts, then 0.
  - Pulse out_ready_i one cycle → first frame retired, in_ready_o=1 next cycle.
  - Second frame is presented with lane0=9.
- Sustained stream: out_ready_i=1, 64 samples back-to-back.
  - 8 frames, no in_ready_o deassertion, each frame bit-exact.
  - out_valid_o high 1 cycle per frame at 8-cycle spacing.
- Early SOP: feed 3 samples (values 1,2,3), then a sop sample 100 followed by 7 samples 101..107.
  - sop_err_o pulses once.
  - Frame lane0=100, lane4=101, lane7=107.
  - No frame containing 1,2,3 is emitted.
- Mid-frame reset: feed 5 samples, assert rst for 1 cycle, then feed 8 samples 200..207.
  - out_valid_o stays 0 until the new frame completes.
  - Emitted frame lane0=200, lane1=204.
- Simultaneous complete/consume: bank0 full and awaiting, bank1 on its 8th accept in the same cycle as out_ready_i=1.
  - Next cycle out_valid_o=1 with bank1 data, full=10, in_ready_o=1.
